// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 raster timing path.
// Holds the default VESA timing, the bus widths and the sync/active bundle type.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;

    // Control bits that travel alongside the pixel data through the pipeline.
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } sync_t;

    localparam int SYNC_W = $bits(sync_t);

    function automatic bit fits_counter(input int total);
        return (total > 0) && (total <= (1 << COORD_W));
    endfunction

    function automatic sync_t idle_sync(input logic hs_pol, input logic vs_pol);
        sync_t s;
        s.hs     = ~hs_pol;
        s.vs     = ~vs_pol;
        s.active = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Bus between the timing controller, the pattern stage and the DAC pins.
// The master side is the timing controller; the slave side is pattern stage plus DAC.
interface vga_timing_ctrl_if
    import vga_timing_pkg::*;
;
    logic [COLOR_W-1:0] iRed;
    logic [COLOR_W-1:0] iGreen;
    logic [COLOR_W-1:0] iBlue;
    logic [COORD_W-1:0] oVGA_X;
    logic [COORD_W-1:0] oVGA_Y;
    logic [COLOR_W-1:0] oVGA_R;
    logic [COLOR_W-1:0] oVGA_G;
    logic [COLOR_W-1:0] oVGA_B;
    logic               oVGA_HS;
    logic               oVGA_VS;
    logic               oVGA_BLANK_n;
    logic               oFRAME_START;

    modport master (
        input  iRed, iGreen, iBlue,
        output oVGA_X, oVGA_Y, oVGA_R, oVGA_G, oVGA_B,
        output oVGA_HS, oVGA_VS, oVGA_BLANK_n, oFRAME_START
    );

    modport slave (
        output iRed, iGreen, iBlue,
        input  oVGA_X, oVGA_Y, oVGA_R, oVGA_G, oVGA_B,
        input  oVGA_HS, oVGA_VS, oVGA_BLANK_n, oFRAME_START
    );

endinterface

// File: rtl/vga_delay_line.sv
// Width x depth shift register with synchronous reset to a fixed value.
// A depth of zero degenerates to a plain wire.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    if (DEPTH == 0) begin : g_wire
        assign o_data = i_data;
    end else begin : g_shift
        logic [WIDTH-1:0] r_stages [DEPTH];

        // NOTE: every stage is reset, unlike a data RAM, so no stale sync or
        // active bit can leak out while the pipeline refills after reset.
        // NOTE: non-blocking assignments let all stages shift on the same edge
        // regardless of statement order.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stages[i] <= RST_VAL;
                end
            end else begin
                r_stages[0] <= i_data;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stages[i] <= r_stages[i-1];
                end
            end
        end

        assign o_data = r_stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster timing generator: h/v counters, registered coordinates to the pattern
// stage, and sync/blank delayed to line up with the returned RGB at the DAC.
module vga_timing_ctrl #(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_LAT = 1
) (
    input  logic                  iVGA_CLK,
    input  logic                  iRST,
    vga_timing_ctrl_if.master     vga
);
    import vga_timing_pkg::*;

    localparam int L_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int L_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (!fits_counter(L_H_TOTAL)) begin : g_bad_h_total
        $error("vga_timing_ctrl: horizontal total %0d does not fit the coordinate counter", L_H_TOTAL);
    end
    if (!fits_counter(L_V_TOTAL)) begin : g_bad_v_total
        $error("vga_timing_ctrl: vertical total %0d does not fit the coordinate counter", L_V_TOTAL);
    end
    if (PIPE_LAT < 0) begin : g_bad_pipe_lat
        $error("vga_timing_ctrl: PIPE_LAT must be non-negative");
    end

    // Window bounds are one bit wider than the counters so a total of 1024 still compares.
    localparam logic [COORD_W:0]   C_H_ACTIVE   = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0]   C_V_ACTIVE   = (COORD_W+1)'(V_ACTIVE);
    localparam logic [COORD_W:0]   C_HS_START   = (COORD_W+1)'(H_ACTIVE + H_FP);
    localparam logic [COORD_W:0]   C_HS_END     = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W:0]   C_VS_START   = (COORD_W+1)'(V_ACTIVE + V_FP);
    localparam logic [COORD_W:0]   C_VS_END     = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] C_H_LAST     = COORD_W'(L_H_TOTAL - 1);
    localparam logic [COORD_W-1:0] C_V_LAST     = COORD_W'(L_V_TOTAL - 1);
    localparam logic [COORD_W-1:0] C_ONE        = COORD_W'(1);
    localparam sync_t              C_SYNC_IDLE  = idle_sync(HS_POL, VS_POL);

    logic [COORD_W-1:0] r_h_cnt;
    logic [COORD_W-1:0] r_v_cnt;
    logic [COORD_W-1:0] w_h_next;
    logic [COORD_W-1:0] w_v_next;
    logic [COORD_W:0]   w_h_ext;
    logic [COORD_W:0]   w_v_ext;
    logic               w_active;
    logic               w_hs_raw;
    logic               w_vs_raw;
    sync_t              w_sync_now;

    // NOTE: defaults come first so no path through the block leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_h_next = r_h_cnt + C_ONE;
        w_v_next = r_v_cnt;
        if (r_h_cnt == C_H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + C_ONE;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    assign w_h_ext  = {1'b0, r_h_cnt};
    assign w_v_ext  = {1'b0, r_v_cnt};
    assign w_active = (w_h_ext < C_H_ACTIVE) && (w_v_ext < C_V_ACTIVE);
    assign w_hs_raw = (w_h_ext >= C_HS_START) && (w_h_ext < C_HS_END);
    assign w_vs_raw = (w_v_ext >= C_VS_START) && (w_v_ext < C_VS_END);

    always_comb begin
        w_sync_now.hs     = w_hs_raw ? HS_POL : ~HS_POL;
        w_sync_now.vs     = w_vs_raw ? VS_POL : ~VS_POL;
        w_sync_now.active = w_active;
    end

    // Coordinate stage: what the pattern stage sees one cycle after the counters.
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_frame_start;
    sync_t              r_sync_coord;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_sync_coord  <= C_SYNC_IDLE;
        end else begin
            r_x           <= w_active ? r_h_cnt : '0;
            r_y           <= w_active ? r_v_cnt : '0;
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            r_sync_coord  <= w_sync_now;
        end
    end

    // Match the pattern stage latency so sync/active arrive with their RGB.
    logic [SYNC_W-1:0] w_sync_dly_bits;
    sync_t             w_sync_dly;

    vga_delay_line #(
        .WIDTH   (SYNC_W),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (C_SYNC_IDLE)
    ) u_sync_dly (
        .clk    (iVGA_CLK),
        .rst    (iRST),
        .i_data (r_sync_coord),
        .o_data (w_sync_dly_bits)
    );

    assign w_sync_dly = sync_t'(w_sync_dly_bits);

    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;
    sync_t              r_sync_out;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_red      <= '0;
            r_green    <= '0;
            r_blue     <= '0;
            r_sync_out <= C_SYNC_IDLE;
        end else begin
            r_red      <= w_sync_dly.active ? vga.iRed   : '0;
            r_green    <= w_sync_dly.active ? vga.iGreen : '0;
            r_blue     <= w_sync_dly.active ? vga.iBlue  : '0;
            r_sync_out <= w_sync_dly;
        end
    end

    assign vga.oVGA_X       = r_x;
    assign vga.oVGA_Y       = r_y;
    assign vga.oFRAME_START = r_frame_start;
    assign vga.oVGA_R       = r_red;
    assign vga.oVGA_G       = r_green;
    assign vga.oVGA_B       = r_blue;
    assign vga.oVGA_HS      = r_sync_out.hs;
    assign vga.oVGA_VS      = r_sync_out.vs;
    assign vga.oVGA_BLANK_n = r_sync_out.active;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl. Horizontal timing is the 640x480 default;
// vertical timing is scaled to 6/2/2/3 lines so whole frames stay short.
module tb_vga_timing_ctrl;

    localparam int H_TOT     = 800;
    localparam int H_ACT     = 640;
    localparam int HS_BEGIN  = 656;
    localparam int HS_WIDTH  = 96;
    localparam int V_ACT     = 6;
    localparam int V_FP      = 2;
    localparam int V_SY      = 2;
    localparam int V_BP      = 3;
    localparam int V_TOT     = V_ACT + V_FP + V_SY + V_BP;
    localparam int VS_BEGIN  = V_ACT + V_FP;
    localparam int FRAME     = H_TOT * V_TOT;
    localparam int OUT_LAT   = 3;

    localparam logic [53:0] RESET_VEC = 54'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ramp_mode = 1'b0;
    logic [9:0] const_r = '0;
    logic [9:0] const_g = '0;
    logic [9:0] const_b = '0;
    logic [9:0] pat_r = '0;
    logic [9:0] pat_g = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl_if vga ();

    vga_timing_ctrl #(
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FP),
        .V_SYNC   (V_SY),
        .V_BP     (V_BP)
    ) dut (
        .iVGA_CLK (clk),
        .iRST     (rst),
        .vga      (vga)
    );

    // Pattern stage stand-in: one register from coordinates to colour.
    always @(posedge clk) begin
        pat_r <= vga.oVGA_X;
        pat_g <= vga.oVGA_Y;
    end

    assign vga.iRed   = ramp_mode ? pat_r : const_r;
    assign vga.iGreen = ramp_mode ? pat_g : const_g;
    assign vga.iBlue  = const_b;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [53:0] outs();
        return {vga.oVGA_X, vga.oVGA_Y, vga.oVGA_R, vga.oVGA_G, vga.oVGA_B,
                vga.oFRAME_START, vga.oVGA_BLANK_n, vga.oVGA_HS, vga.oVGA_VS};
    endfunction

    // Holds reset for 3 edges, releases it and checks the first 3 edges after release.
    task automatic test_reset(input string tag);
        logic [53:0] exp_v;
        rst = 1'b1;
        ramp_mode = 1'b0;
        const_r = 10'h3FF;
        const_g = 10'h155;
        const_b = 10'h2AA;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (outs() !== RESET_VEC) begin
                n_bad++;
                $display("FAIL %s reset_edge%0d: got %h expected %h", tag, i, outs(), RESET_VEC);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= OUT_LAT; k++) begin
            tick();
            case (k)
                1:       exp_v = {10'd0, 10'd0, 30'd0, 1'b1, 1'b0, 1'b1, 1'b1};
                2:       exp_v = {10'd1, 10'd0, 30'd0, 1'b0, 1'b0, 1'b1, 1'b1};
                default: exp_v = {10'd2, 10'd0, 10'h3FF, 10'h155, 10'h2AA, 1'b0, 1'b1, 1'b1, 1'b1};
            endcase
            n_cmp++;
            if (outs() !== exp_v) begin
                n_bad++;
                $display("FAIL %s release_edge%0d: got %h expected %h", tag, k, outs(), exp_v);
            end
        end
    endtask

    // Entered right at the BLANK_n rise of line 0; watches two full lines.
    task automatic test_hsync_line();
        int blank_hi = 1;
        int hs_low = 0;
        int vs_low = 0;
        int falls[$];
        int rises[$];
        logic prev_hs = 1'b1;
        for (int c = 1; c < 2 * H_TOT; c++) begin
            tick();
            if (vga.oVGA_BLANK_n) blank_hi++;
            if (!vga.oVGA_HS) hs_low++;
            if (!vga.oVGA_VS) vs_low++;
            if (prev_hs && !vga.oVGA_HS) falls.push_back(c);
            if (!prev_hs && vga.oVGA_HS) rises.push_back(c);
            prev_hs = vga.oVGA_HS;
        end
        n_cmp++;
        if (blank_hi !== 2 * H_ACT) begin
            n_bad++;
            $display("FAIL hline blank_high_cycles: got %0d expected %0d", blank_hi, 2 * H_ACT);
        end
        n_cmp++;
        if (hs_low !== 2 * HS_WIDTH) begin
            n_bad++;
            $display("FAIL hline hs_low_cycles: got %0d expected %0d", hs_low, 2 * HS_WIDTH);
        end
        n_cmp++;
        if (vs_low !== 0) begin
            n_bad++;
            $display("FAIL hline vs_low_cycles: got %0d expected 0", vs_low);
        end
        n_cmp++;
        if (falls.size() !== 2 || rises.size() < 1) begin
            n_bad++;
            $display("FAIL hline hs_edge_count: got %0d falls %0d rises expected 2 falls", falls.size(), rises.size());
        end else begin
            n_cmp++;
            if (falls[0] !== HS_BEGIN) begin
                n_bad++;
                $display("FAIL hline hs_fall_offset: got %0d expected %0d", falls[0], HS_BEGIN);
            end
            n_cmp++;
            if (falls[1] - falls[0] !== H_TOT) begin
                n_bad++;
                $display("FAIL hline hs_period: got %0d expected %0d", falls[1] - falls[0], H_TOT);
            end
            n_cmp++;
            if (rises[0] - falls[0] !== HS_WIDTH) begin
                n_bad++;
                $display("FAIL hline hs_width: got %0d expected %0d", rises[0] - falls[0], HS_WIDTH);
            end
        end
    endtask

    // Samples are indexed by k = edges since reset release.
    task automatic test_vsync_frames();
        int fs_k[$];
        int vs_fall_k[$];
        int vs_low = 0;
        int lines = 0;
        logic prev_vs = 1'b1;
        logic prev_bl = 1'b1;
        test_reset("vsync_start");
        for (int k = OUT_LAT + 1; k <= 2 * FRAME + 100; k++) begin
            tick();
            if (vga.oFRAME_START) fs_k.push_back(k);
            if (!vga.oVGA_VS) vs_low++;
            if (prev_vs && !vga.oVGA_VS) vs_fall_k.push_back(k);
            if (!prev_bl && vga.oVGA_BLANK_n && k >= FRAME + 1 && k < 2 * FRAME + 1) lines++;
            prev_vs = vga.oVGA_VS;
            prev_bl = vga.oVGA_BLANK_n;
        end
        n_cmp++;
        if (fs_k.size() !== 2) begin
            n_bad++;
            $display("FAIL vframe frame_start_count: got %0d expected 2", fs_k.size());
        end else begin
            n_cmp++;
            if (fs_k[0] !== FRAME + 1 || fs_k[1] - fs_k[0] !== FRAME) begin
                n_bad++;
                $display("FAIL vframe frame_start_period: got %0d/%0d expected %0d/%0d", fs_k[0], fs_k[1] - fs_k[0], FRAME + 1, FRAME);
            end
        end
        n_cmp++;
        if (vs_fall_k.size() !== 2) begin
            n_bad++;
            $display("FAIL vframe vs_fall_count: got %0d expected 2", vs_fall_k.size());
        end else begin
            n_cmp++;
            if (vs_fall_k[0] !== VS_BEGIN * H_TOT + OUT_LAT || vs_fall_k[1] - vs_fall_k[0] !== FRAME) begin
                n_bad++;
                $display("FAIL vframe vs_start_period: got %0d/%0d expected %0d/%0d", vs_fall_k[0], vs_fall_k[1] - vs_fall_k[0], VS_BEGIN * H_TOT + OUT_LAT, FRAME);
            end
        end
        n_cmp++;
        if (vs_low !== 2 * V_SY * H_TOT) begin
            n_bad++;
            $display("FAIL vframe vs_low_cycles: got %0d expected %0d", vs_low, 2 * V_SY * H_TOT);
        end
        n_cmp++;
        if (lines !== V_ACT) begin
            n_bad++;
            $display("FAIL vframe active_lines: got %0d expected %0d", lines, V_ACT);
        end
    endtask

    task automatic test_color_gating();
        int bad = 0;
        int act = 0;
        logic [29:0] first_bad = '0;
        logic [29:0] exp_rgb;
        ramp_mode = 1'b0;
        const_r = 10'h3FF;
        const_g = 10'h155;
        const_b = 10'h000;
        tick();
        tick();
        for (int c = 0; c < FRAME; c++) begin
            tick();
            exp_rgb = vga.oVGA_BLANK_n ? {10'h3FF, 10'h155, 10'h000} : 30'd0;
            if (vga.oVGA_BLANK_n) act++;
            if ({vga.oVGA_R, vga.oVGA_G, vga.oVGA_B} !== exp_rgb) begin
                if (bad == 0) first_bad = {vga.oVGA_R, vga.oVGA_G, vga.oVGA_B};
                bad++;
            end
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL color_gate bad_cycles: got %0d (first rgb %h) expected 0", bad, first_bad);
        end
        n_cmp++;
        if (act !== V_ACT * H_ACT) begin
            n_bad++;
            $display("FAIL color_gate active_cycles: got %0d expected %0d", act, V_ACT * H_ACT);
        end
    endtask

    // With iRed=X and iGreen=Y through one register, R/G must replay h/v of each active pixel.
    task automatic test_pattern_ramp();
        int bad = 0;
        int first_bad_k = -1;
        logic [33:0] exp_v;
        logic [33:0] got_v;
        logic [33:0] first_got = '0;
        logic [33:0] first_exp = '0;
        logic [10:0] at_639 = '0;
        logic [10:0] at_640 = '1;
        logic [10:0] line1_first = '0;
        test_reset("ramp_start");
        const_b = 10'h000;
        ramp_mode = 1'b1;
        for (int k = OUT_LAT + 1; k < FRAME + H_TOT; k++) begin
            int c;
            int h;
            int v;
            logic act;
            tick();
            c = k - OUT_LAT;
            h = c % H_TOT;
            v = (c / H_TOT) % V_TOT;
            act = (h < H_ACT) && (v < V_ACT);
            exp_v = {act ? 10'(h) : 10'd0, act ? 10'(v) : 10'd0, 10'd0, act,
                     !(h >= HS_BEGIN && h < HS_BEGIN + HS_WIDTH), !(v >= VS_BEGIN && v < VS_BEGIN + V_SY)};
            got_v = {vga.oVGA_R, vga.oVGA_G, vga.oVGA_B, vga.oVGA_BLANK_n, vga.oVGA_HS, vga.oVGA_VS};
            if (c == H_ACT - 1) at_639 = {vga.oVGA_BLANK_n, vga.oVGA_R};
            if (c == H_ACT) at_640 = {vga.oVGA_BLANK_n, vga.oVGA_R};
            if (c == H_TOT) line1_first = {vga.oVGA_BLANK_n, vga.oVGA_R};
            if (got_v !== exp_v) begin
                if (bad == 0) begin
                    first_bad_k = k;
                    first_got = got_v;
                    first_exp = exp_v;
                end
                bad++;
            end
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL ramp bad_cycles: got %0d, first at k=%0d got %h expected %h", bad, first_bad_k, first_got, first_exp);
        end
        n_cmp++;
        if (at_639 !== {1'b1, 10'd639}) begin
            n_bad++;
            $display("FAIL ramp last_pixel: got %h expected %h", at_639, {1'b1, 10'd639});
        end
        n_cmp++;
        if (at_640 !== 11'd0) begin
            n_bad++;
            $display("FAIL ramp first_blank: got %h expected 000", at_640);
        end
        n_cmp++;
        if (line1_first !== {1'b1, 10'd0}) begin
            n_bad++;
            $display("FAIL ramp line1_first_pixel: got %h expected %h", line1_first, {1'b1, 10'd0});
        end
        ramp_mode = 1'b0;
    endtask

    // Runs to counter state (300,4), then reasserts reset and expects a clean restart.
    task automatic test_mid_frame_reset();
        test_reset("mid_pre");
        for (int k = OUT_LAT + 1; k <= 4 * H_TOT + 300; k++) tick();
        n_cmp++;
        if ({vga.oVGA_X, vga.oVGA_Y, vga.oVGA_BLANK_n} !== {10'd299, 10'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL mid position: got x=%0d y=%0d bl=%b expected x=299 y=4 bl=1", vga.oVGA_X, vga.oVGA_Y, vga.oVGA_BLANK_n);
        end
        test_reset("mid_restart");
    endtask

    initial begin
        @(negedge clk);
        test_reset("power_on");
        test_hsync_line();
        test_vsync_frames();
        test_color_gating();
        test_pattern_ramp();
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Raster timing generator for the DE0 VGA path, sitting directly upstream of the VGA pattern stage. It runs horizontal and vertical counters, drives registered pixel coordinates into the pattern stage, and registers the 10-bit RGB returned by that stage. It delays HS, VS and BLANK so they line up with that RGB at the DAC pins. RGB is forced to zero outside the active region.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, asserted HS level (0 = active low)
VS_POL, 0, asserted VS level
PIPE_LAT, 1, register latency of the downstream pattern stage (coordinate in to RGB out)

Ports:
iVGA_CLK  in  1  pixel clock; the only clock
iRST  in  1  synchronous, active-high reset
iRed  in  10  red from pattern stage
iGreen  in  10  green from pattern stage
iBlue  in  10  blue from pattern stage
oVGA_X  out  10  pixel X to pattern stage
oVGA_Y  out  10  pixel Y to pattern stage
oVGA_R  out  10  red to DAC
oVGA_G  out  10  green to DAC
oVGA_B  out  10  blue to DAC
oVGA_HS  out  1  horizontal sync
oVGA_VS  out  1  vertical sync
oVGA_BLANK_n  out  1  low while blanking
oFRAME_START  out  1  one-cycle pulse, aligned with oVGA_X/Y=(0,0)

Behaviour:
- Single clock: iVGA_CLK. Reset: iRST, synchronous, active-high.
- Totals: H_TOTAL = 800 cycles, V_TOTAL = 525 lines, one frame = 420000 cycles.
- Horizontal order is active, FP, sync, BP. Vertical order is the same.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments only on h_cnt wrap and wraps 0 after V_TOTAL-1.
- Counter state (h,v) at cycle n. Definitions:
  - active = h<H_ACTIVE && v<V_ACTIVE
  - hs_raw = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_raw = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- Cycle n+1 (coordinate register):
  - oVGA_X = active ? h : 0
  - oVGA_Y = active ? v : 0
  - oFRAME_START = (h==0 && v==0)
- The pattern stage returns RGB for (h,v) at cycle n+1+PIPE_LAT.
- Cycle n+2+PIPE_LAT (output register):
  - oVGA_R/G/B = (delayed active) ? iRed/iGreen/iBlue : 0
  - oVGA_HS = hs_raw ? HS_POL : ~HS_POL; oVGA_VS likewise with VS_POL
  - oVGA_BLANK_n = delayed active
- Total delay for HS, VS and active: 2+PIPE_LAT register stages from counter state.
- Reset values:
  - counters 0; oVGA_X, oVGA_Y, oVGA_R/G/B all 0
  - oFRAME_START 0; oVGA_BLANK_n 0
  - oVGA_HS = ~HS_POL, oVGA_VS = ~VS_POL (inactive)
  - every delay-line stage holds blank/inactive
- No garbage is emitted during pipeline fill.
- First edge after iRST falls: counter state (0,0).
  - oVGA_X/Y = (0,0) and oFRAME_START = 1 one cycle later.
  - oVGA_BLANK_n rises 2+PIPE_LAT cycles later (3 at default).
- Reset mid-frame: all state returns to reset values on the next edge, regardless of position. Restart is identical to power-on.
- Boundary wraps:
  - h=799 to 0 and v=524 to 0 occur on the same edge.
  - v increments on the same edge that h wraps.
- Parameter constraint: the H_* sum ≤ 1024 and the V_* sum ≤ 1024 (10-bit counters). This is checked at elaboration.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 constants (H_ACTIVE..V_BP defaults)
  - derived H_TOTAL, V_TOTAL, H_SYNC_START, V_SYNC_START
  - COORD_W = 10, COLOR_W = 10
- One sub-module: vga_delay_line, a parameterised width × depth shift register with synchronous reset to a parameterised value. It is used for the HS/VS/active pipeline.

Test Plan:
1. Release iRST at cycle 0 -> oVGA_X/Y=(0,0) and oFRAME_START=1 at cycle 1. oVGA_BLANK_n=0 through cycle 2, rises at cycle 3. oVGA_HS=1 throughout.
2. Free-run one line -> oVGA_HS low for exactly 96 cycles, falling edge 656 cycles after the BLANK_n rise. HS period 800. BLANK_n high for 640 cycles per active line.
3. Free-run two frames -> oVGA_VS low for exactly 1600 cycles, starting at line 490. VS period and oFRAME_START period both 420000. 480 active lines per frame.
4. Hold iRed=10'h3FF, iGreen=10'h155, iBlue=0 -> oVGA_R=3FF and oVGA_G=155 only while BLANK_n=1. All channels 0 during blanking.
5. Bench pattern model (1-cycle register, iRed=oVGA_X) -> oVGA_R reads 0,1,…,639 across each active line. First value appears with the BLANK_n rise; no off-by-one at 639 to blank.
6. Assert iRST for 3 cycles at (h=300, v=200) -> all outputs at reset values from the first reset edge. Restart matches scenario 1 exactly.
